// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: runs one shared DSP engine over left then right channel of each frame,
// with a per-channel watchdog that passes the input through if the engine stalls.
module dsp_frame_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             Clk_Fast,
    input  logic             Rst,
    input  logic             Frame_Valid,
    input  logic [WIDTH-1:0] Left_In,
    input  logic [WIDTH-1:0] Right_In,
    input  logic             Bypass,
    output logic             Eng_Req,
    output logic             Eng_Chan,
    output logic [WIDTH-1:0] Eng_Data,
    input  logic             Eng_Done,
    input  logic [WIDTH-1:0] Eng_Result,
    output logic [WIDTH-1:0] Left_Out,
    output logic [WIDTH-1:0] Right_Out,
    output logic             Valid_Out,
    output logic             Busy,
    output logic             Timeout_Err,
    output logic [7:0]       Overrun_Count
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, L_WAIT, R_WAIT, DONE} state_t;

    state_t state, nxt;
    logic [WIDTH-1:0] cap_l, cap_r, res_l, res_r, nres_l, nres_r;
    logic [CW-1:0] wd;
    logic waiting, expired;

    assign waiting = state == L_WAIT || state == R_WAIT;
    // Eng_Done in the final watchdog cycle still counts as a real completion
    assign expired = waiting && !Eng_Done && wd == CW'(TIMEOUT - 1);

    always_comb begin
        nxt    = state;
        nres_l = res_l;
        nres_r = res_r;
        case (state)
            IDLE: if (Frame_Valid) begin
                nxt = Bypass ? DONE : L_WAIT;
                if (Bypass) begin
                    nres_l = Left_In;
                    nres_r = Right_In;
                end
            end
            L_WAIT: if (Eng_Done || expired) begin
                nres_l = Eng_Done ? Eng_Result : cap_l;
                nxt    = R_WAIT;
            end
            R_WAIT: if (Eng_Done || expired) begin
                nres_r = Eng_Done ? Eng_Result : cap_r;
                nxt    = DONE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Fast or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            cap_l         <= '0;
            cap_r         <= '0;
            res_l         <= '0;
            res_r         <= '0;
            wd            <= '0;
            Left_Out      <= '0;
            Right_Out     <= '0;
            Overrun_Count <= '0;
        end else begin
            state <= nxt;
            res_l <= nres_l;
            res_r <= nres_r;
            wd    <= (waiting && nxt == state) ? wd + 1'b1 : '0;
            if (state == IDLE && Frame_Valid) begin
                cap_l <= Left_In;
                cap_r <= Right_In;
            end
            if (nxt == DONE && state != DONE) begin
                Left_Out  <= nres_l;
                Right_Out <= nres_r;
            end
            if (state != IDLE && Frame_Valid && Overrun_Count != 8'hFF)
                Overrun_Count <= Overrun_Count + 8'd1;
        end
    end

    assign Eng_Req     = waiting;
    assign Eng_Chan    = state == R_WAIT;
    assign Eng_Data    = Eng_Chan ? cap_r : cap_l;
    assign Valid_Out   = state == DONE;
    assign Busy        = state != IDLE;
    assign Timeout_Err = expired;
endmodule

// File: doc/dsp_frame_sequencer.md
# dsp_frame_sequencer

Fast-domain controller that sequences one shared DSP engine over both channels of each stereo audio frame. It sits between the slow-to-fast receive CDC (frame-complete pulse plus left/right samples) and the fast-to-slow transmit CDC. It serialises left then right through the engine with a req/done handshake and presents both results with a single valid pulse. A per-channel watchdog bounds latency so a frame always finishes within one 44.1 kHz sample period at 6 MHz (about 136 cycles).

## Interface
- WIDTH, 16, sample width in bits
- TIMEOUT, 64, maximum engine wait per channel in cycles; 2*TIMEOUT+1 must not exceed 136
- Clk_Fast  in  1  6 MHz system clock; all logic on the rising edge
- Rst  in  1  reset, asynchronous and active-high
- Frame_Valid  in  1  one-cycle pulse: Left_In/Right_In hold a complete frame
- Left_In, Right_In  in  WIDTH  received samples, valid in the Frame_Valid cycle
- Bypass  in  1  sampled with Frame_Valid; 1 = skip the engine for that frame
- Eng_Req  out  1  transaction request, level
- Eng_Chan  out  1  channel of the current transaction: 0 = left, 1 = right
- Eng_Data  out  WIDTH  operand for the current transaction
- Eng_Done  in  1  one-cycle completion from the engine
- Eng_Result  in  WIDTH  engine result, valid with Eng_Done
- Left_Out, Right_Out  out  WIDTH  processed frame, registered
- Valid_Out  out  1  one-cycle pulse: Left_Out/Right_Out updated
- Busy  out  1  high in every state except IDLE
- Timeout_Err  out  1  one-cycle pulse when a channel times out
- Overrun_Count  out  8  count of dropped frames, saturating

## Operation
- States: IDLE, L_WAIT, R_WAIT, DONE.
- IDLE, Frame_Valid=1: capture Left_In and Right_In into cap_l and cap_r.
  - Bypass=1: res_l=cap_l, res_r=cap_r, go to DONE.
  - Bypass=0: go to L_WAIT.
- L_WAIT: Eng_Req=1, Eng_Chan=0, Eng_Data=cap_l.
  - Eng_Done=1: res_l=Eng_Result, go to R_WAIT.
- R_WAIT: Eng_Req=1, Eng_Chan=1, Eng_Data=cap_r.
  - Eng_Done=1: res_r=Eng_Result, go to DONE.
- Watchdog counter:
  - Cleared on entry to L_WAIT and R_WAIT; increments each cycle in a wait state.
  - Counter at TIMEOUT-1 with Eng_Done=0: the result for that channel is its captured input (pass-through).
  - That cycle also pulses Timeout_Err and advances the state as if done.
  - Eng_Done and timeout in the same cycle: Eng_Done wins, no error.
- DONE: lasts one cycle, then IDLE.
  - Left_Out=res_l and Right_Out=res_r are loaded on the edge entering DONE.
  - Valid_Out=1 for the whole DONE cycle.
- Frame_Valid in any state other than IDLE: the frame is dropped; captures and outputs are unchanged.
  - Overrun_Count increments and saturates at 255.
- Eng_Done outside L_WAIT and R_WAIT is ignored.
- Eng_Chan and Eng_Data change only on the edge after a completion. They are stable while Eng_Req=1 within a transaction.
- Eng_Req stays high from L_WAIT straight into R_WAIT; the engine must treat the Eng_Chan change as a new transaction.
- Eng_Req is 0 in IDLE and DONE.
- Left_Out and Right_Out hold their value between frames.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0, including Overrun_Count.
  - Captures, results and watchdog are 0.
  - An in-flight transaction is abandoned with no Valid_Out.
  - The first Frame_Valid after Rst falls is accepted normally.
- Bypass latency: Frame_Valid sampled at edge E0, Valid_Out high in the cycle after E0 (1 cycle).
- Engine latency, Eng_Done returned in the first request cycle:
  - Eng_Req high after E0.
  - Eng_Done sampled at E1 and E2.
  - Valid_Out high after E2 (3 cycles).
- Worst case, both channels time out: Valid_Out high 2*TIMEOUT+1 cycles after Frame_Valid (129 at default).
- Overrun boundary: Frame_Valid in the DONE cycle is dropped; Frame_Valid in the following IDLE cycle is accepted.
- Timeout_Err and Valid_Out are never high in the same cycle.

## Test plan
- Bypass: Frame_Valid with Left_In=0x1234, Right_In=0xABCD, Bypass=1 -> Valid_Out one cycle later with outputs 0x1234/0xABCD, Eng_Req never high.
- Zero-wait engine returning ~data: Left_In=0x00FF, Right_In=0x0F0F -> Eng_Chan 0 then 1, Valid_Out 3 cycles after Frame_Valid, outputs 0xFF00/0xF0F0.
- Left timeout, right done at wait cycle 5 with result 0x5555, Left_In=0x0101 -> Timeout_Err pulse at cycle 64 of L_WAIT, outputs 0x0101/0x5555.
- Overrun: second Frame_Valid 10 cycles into L_WAIT -> Overrun_Count=1, first frame's outputs unaffected; 300 such pulses -> Overrun_Count=255.
- Reset mid-R_WAIT: Rst pulse -> outputs 0, Eng_Req 0, no Valid_Out; next frame completes normally.
- Eng_Done pulses in IDLE and DONE -> no state change and no output change.
